// File: rtl/svo_stream_sink.sv
// svo_stream_sink
//
// Consumer end of the SVO pixel AXI-Stream (tuser[0] marks start of frame).
// This block accepts pixels under a programmable backpressure pattern and
// follows the frame geometry against the SOF marker. It counts framing errors
// and reports per-frame statistics. It serves as a bring-up sink and as a
// stream health monitor ahead of the encoder.
//
// Parameters:
//   HOR_PIXELS     - active pixels per line (>= 1)
//   VER_PIXELS     - active lines per frame (>= 1)
//   BITS_PER_PIXEL - tdata width ({b,g,r})
//   READY_PERIOD   - tready is high 1 cycle out of every READY_PERIOD (>= 1)
//
// Ports:
//   clk             - clock
//   resetn          - synchronous, active-low reset
//   in_axis_tvalid  - pixel valid
//   in_axis_tready  - sink ready (registered)
//   in_axis_tdata   - pixel data
//   in_axis_tuser   - start of frame, set on pixel (0,0)
//   frame_done      - one-cycle pulse after the last pixel of a complete frame
//   frame_sum       - mod-2^32 sum of all beats of the last complete frame
//   frame_count     - complete frames received, wraps at 2^16
//   err_sof_early   - SOF seen before frame end, saturating at 255
//   err_sof_missing - pixel (0,0) beats without SOF, saturating at 255
//   locked          - high after a clean complete frame, cleared by framing errors

module svo_stream_sink #(
    parameter int unsigned HOR_PIXELS     = 640,
    parameter int unsigned VER_PIXELS     = 480,
    parameter int unsigned BITS_PER_PIXEL = 24,
    parameter int unsigned READY_PERIOD   = 1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      in_axis_tvalid,
    output logic                      in_axis_tready,
    input  logic [BITS_PER_PIXEL-1:0] in_axis_tdata,
    input  logic                      in_axis_tuser,
    output logic                      frame_done,
    output logic [31:0]               frame_sum,
    output logic [15:0]               frame_count,
    output logic [7:0]                err_sof_early,
    output logic [7:0]                err_sof_missing,
    output logic                      locked
);

    // Counter widths. Each is at least 1 bit, so that 1-pixel and 1-line
    // geometries and READY_PERIOD=1 stay legal.
    localparam int unsigned HW = (HOR_PIXELS > 1)   ? $clog2(HOR_PIXELS)   : 1;
    localparam int unsigned VW = (VER_PIXELS > 1)   ? $clog2(VER_PIXELS)   : 1;
    localparam int unsigned RW = (READY_PERIOD > 1) ? $clog2(READY_PERIOD) : 1;

    localparam logic [HW-1:0] HLast = HW'(HOR_PIXELS - 1);
    localparam logic [VW-1:0] VLast = VW'(VER_PIXELS - 1);
    localparam logic [RW-1:0] RLast = RW'(READY_PERIOD - 1);

    localparam logic [0:0] StWaitSof = 1'b0;
    localparam logic [0:0] StInFrame = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [RW-1:0] ready_cnt_q, ready_cnt_d;
    logic          tready_q, tready_d;
    logic [0:0]    state_q, state_d;
    logic [HW-1:0] hpos_q, hpos_d;
    logic [VW-1:0] vpos_q, vpos_d;
    logic [31:0]   running_sum_q, running_sum_d;
    logic          frame_done_q, frame_done_d;
    logic [31:0]   frame_sum_q, frame_sum_d;
    logic [15:0]   frame_count_q, frame_count_d;
    logic [7:0]    err_early_q, err_early_d;
    logic [7:0]    err_missing_q, err_missing_d;
    logic          locked_q, locked_d;

    // ------------------------------------------------------------------
    // Backpressure: free-running divider, independent of tvalid
    // ------------------------------------------------------------------
    always_comb begin
        ready_cnt_d = (ready_cnt_q == RLast) ? '0 : ready_cnt_q + RW'(1);
        tready_d    = (ready_cnt_q == RLast);
    end

    // ------------------------------------------------------------------
    // Beat classification
    // ------------------------------------------------------------------
    logic        accept;
    logic        at_origin;
    logic [31:0] tdata_ext;
    logic        beat_start;    // beat is pixel (0,0) of a (re)started frame
    logic        beat_cont;     // beat continues the current frame
    logic        beat_early;    // SOF before the frame end
    logic        beat_missing;  // pixel (0,0) arrived without SOF

    assign accept    = in_axis_tvalid && tready_q;
    assign at_origin = (hpos_q == '0) && (vpos_q == '0);
    // Truncation for widths over 32 bits is harmless, because the sum is mod 2^32.
    assign tdata_ext = 32'(in_axis_tdata);

    always_comb begin
        beat_start   = 1'b0;
        beat_cont    = 1'b0;
        beat_early   = 1'b0;
        beat_missing = 1'b0;
        if (accept) begin
            case (state_q)
                StWaitSof: begin
                    // Non-SOF beats are dropped silently while hunting for SOF.
                    beat_start = in_axis_tuser;
                end
                StInFrame: begin
                    if (in_axis_tuser) begin
                        beat_early = !at_origin;
                        beat_start = 1'b1;
                    end else if (at_origin) begin
                        beat_missing = 1'b1;
                    end else begin
                        beat_cont = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Position, running sum and per-frame results
    // ------------------------------------------------------------------
    logic [HW-1:0] eff_h;
    logic [VW-1:0] eff_v;
    logic [31:0]   sum_next;
    logic          eff_last;

    always_comb begin
        // A started beat always sits at (0,0). A continued beat sits at the
        // tracked position.
        eff_h    = beat_start ? '0 : hpos_q;
        eff_v    = beat_start ? '0 : vpos_q;
        sum_next = beat_start ? tdata_ext : running_sum_q + tdata_ext;
        eff_last = (eff_h == HLast) && (eff_v == VLast);
    end

    always_comb begin
        state_d       = state_q;
        hpos_d        = hpos_q;
        vpos_d        = vpos_q;
        running_sum_d = running_sum_q;
        frame_done_d  = 1'b0;
        frame_sum_d   = frame_sum_q;
        frame_count_d = frame_count_q;
        err_early_d   = err_early_q;
        err_missing_d = err_missing_q;
        locked_d      = locked_q;

        if (beat_early) begin
            err_early_d = (err_early_q == 8'hFF) ? err_early_q : err_early_q + 8'd1;
            locked_d    = 1'b0;
        end

        if (beat_missing) begin
            err_missing_d = (err_missing_q == 8'hFF) ? err_missing_q : err_missing_q + 8'd1;
            locked_d      = 1'b0;
            state_d       = StWaitSof;
        end

        if (beat_start || beat_cont) begin
            state_d       = StInFrame;
            running_sum_d = sum_next;

            if (eff_h == HLast) begin
                hpos_d = '0;
                vpos_d = (eff_v == VLast) ? '0 : eff_v + VW'(1);
            end else begin
                hpos_d = eff_h + HW'(1);
                vpos_d = eff_v;
            end

            // An early SOF always lands at (0,0). That position is the last
            // pixel only in a 1x1 frame, where an early SOF cannot occur.
            // So an early SOF never completes a frame.
            if (eff_last) begin
                frame_sum_d   = sum_next;
                frame_done_d  = 1'b1;
                frame_count_d = frame_count_q + 16'd1;
                locked_d      = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ready_cnt_q   <= '0;
            tready_q      <= 1'b0;
            state_q       <= StWaitSof;
            hpos_q        <= '0;
            vpos_q        <= '0;
            running_sum_q <= '0;
            frame_done_q  <= 1'b0;
            frame_sum_q   <= '0;
            frame_count_q <= '0;
            err_early_q   <= '0;
            err_missing_q <= '0;
            locked_q      <= 1'b0;
        end else begin
            ready_cnt_q   <= ready_cnt_d;
            tready_q      <= tready_d;
            state_q       <= state_d;
            hpos_q        <= hpos_d;
            vpos_q        <= vpos_d;
            running_sum_q <= running_sum_d;
            frame_done_q  <= frame_done_d;
            frame_sum_q   <= frame_sum_d;
            frame_count_q <= frame_count_d;
            err_early_q   <= err_early_d;
            err_missing_q <= err_missing_d;
            locked_q      <= locked_d;
        end
    end

    assign in_axis_tready  = tready_q;
    assign frame_done      = frame_done_q;
    assign frame_sum       = frame_sum_q;
    assign frame_count     = frame_count_q;
    assign err_sof_early   = err_early_q;
    assign err_sof_missing = err_missing_q;
    assign locked          = locked_q;

endmodule

// File: doc/svo_stream_sink.md
Name: svo_stream_sink

Overview:
- Consumer end of the SVO pixel AXI-Stream (tuser[0] = start of frame), i.e. the receiver for the test-card and pattern generators.
- Accepts pixels with a programmable backpressure pattern.
- Tracks frame geometry against the SOF marker and flags framing errors.
- Produces per-frame statistics: pixel checksum and frame count.
- Used as a simulation/bring-up sink and as an on-chip stream health monitor ahead of the encoder.

Parameters:
- HOR_PIXELS, 640, active pixels per line.
- VER_PIXELS, 480, active lines per frame.
- BITS_PER_PIXEL, 24, tdata width ({b,g,r}).
- READY_PERIOD, 1, tready is asserted 1 cycle out of every READY_PERIOD; 1 = always ready; must be >= 1.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- in_axis_tvalid  in  1  pixel valid
- in_axis_tready  out  1  sink ready (registered)
- in_axis_tdata  in  BITS_PER_PIXEL  pixel data
- in_axis_tuser  in  1  start of frame, set on pixel (0,0)
- frame_done  out  1  one-cycle pulse after the last pixel of a complete frame is accepted
- frame_sum  out  32  modulo-2^32 sum of all tdata beats of the last complete frame (tdata zero-extended)
- frame_count  out  16  complete frames received, wraps at 2^16
- err_sof_early  out  8  count of SOF seen before the frame end, saturating at 255
- err_sof_missing  out  8  count of pixel (0,0) beats without SOF, saturating at 255
- locked  out  1  high after one clean complete frame; cleared by any framing error

Behaviour:
- Reset (resetn=0 at a clk edge):
  - All outputs go to 0: tready, frame_done, frame_sum, frame_count, both error counters, locked.
  - Internal state: ready_cnt=0, hpos=vpos=0, running_sum=0, state=WAIT_SOF.
  - Reset mid-frame discards the partial frame; no frame_done is generated.
- Backpressure:
  - ready_cnt is free-running 0..READY_PERIOD-1 and is independent of tvalid.
  - Each cycle, tready <= (ready_cnt == READY_PERIOD-1).
  - With READY_PERIOD=1, tready=1 from the first cycle after reset release.
- Transfer: a beat is accepted when tvalid && tready at a clk edge. No other signal is sampled for a beat.
- State WAIT_SOF:
  - Accepted beats with tuser=0 are discarded; no counters change.
  - A beat with tuser=1 is pixel (0,0): running_sum <= tdata, hpos <= 1, state <= IN_FRAME.
- State IN_FRAME, per accepted beat:
  - Position counters: hpos wraps to 0 at HOR_PIXELS-1 and increments vpos. Pixel (HOR_PIXELS-1, VER_PIXELS-1) is the last pixel.
  - tuser=1 with (hpos,vpos) != (0,0) (early SOF):
    - err_sof_early increments (saturating); locked <= 0.
    - The beat restarts the frame as pixel (0,0): running_sum <= tdata, hpos <= 1, vpos <= 0.
  - (hpos,vpos) == (0,0) with tuser=0 (missing SOF):
    - err_sof_missing increments (saturating); locked <= 0.
    - state <= WAIT_SOF; the beat is discarded.
  - (hpos,vpos) == (0,0) with tuser=1: normal frame start, running_sum <= tdata.
  - Otherwise running_sum <= running_sum + tdata.
  - Last pixel (tuser=0):
    - frame_sum <= running_sum + tdata; frame_done <= 1 for exactly one cycle.
    - frame_count <= frame_count + 1; locked <= 1.
    - hpos = vpos = 0; state stays IN_FRAME.
- Latency: frame_done, frame_sum, frame_count and locked update on the edge that accepts the last pixel, so they are visible in the following cycle.
- frame_sum holds its value until the next complete frame.
- Simultaneous events:
  - A last-pixel position carrying tuser=1 counts as an early SOF, not a frame completion.
  - HOR_PIXELS=1 and VER_PIXELS=1 must both be legal; with both at 1, every SOF beat completes a frame.
- Arithmetic:
  - All sums are 32-bit wrapping.
  - hpos/vpos are sized by $clog2 of their limits, minimum 1 bit.

Test Plan:
- HOR=4, VER=2, READY_PERIOD=1; two frames of tdata=1..8 with SOF on the first beat -> frame_done pulses twice, frame_sum=36 each time, frame_count=2, locked=1, error counters 0.
- READY_PERIOD=3, tvalid held high -> tready is high exactly every 3rd cycle; the frame still sums to 36 and frame_done fires once after the 8th accepted beat.
- 3 leading beats with tuser=0 before the first SOF -> beats are ignored, no errors, first frame_sum=36.
- SOF re-asserted on the 5th beat of a frame, followed by a full 8-beat frame -> err_sof_early=1, locked=0; the next frame completes with frame_sum=36 and locked=1.
- After a complete frame, the next (0,0) beat carries tuser=0 -> err_sof_missing=1, locked=0; following beats are ignored until SOF, then a normal frame completes.
- resetn pulsed low after 5 beats of a frame -> all outputs return to 0, no frame_done; a fresh frame afterwards gives frame_count=1 and frame_sum=36.
